// File: rtl/memory_access_pkg.sv
// Shared definitions for the MEM stage: opcodes, funct3 codes, FSM states
// and the byte-lane mask helper used by the alignment unit.
package memory_access_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WB     = 2'd2
  } state_e;

  // Byte-enable mask for an access of the given size code (funct3[1:0])
  // starting at byte offset a within the word.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] m;
    unique case (size)
      2'b00:   m = 4'b0001 << a;
      2'b01:   m = 4'b0011 << a;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/memory_access_lsu_align.sv
// Combinational load/store alignment unit.
//   opcode, funct3, addr_lo : instruction fields and effective-address byte offset
//   store_data / rdata      : rs2 store data / raw memory read data
//   is_mem, is_store        : instruction classification
//   fault                   : misaligned access or illegal funct3 (memory ops only)
//   be, wdata               : byte enables and lane-replicated store data
//   lmd                     : extracted and sign/zero-extended load data
module memory_access_lsu_align
  import memory_access_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic        is_mem,
  output logic        is_store,
  output logic        fault,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] lmd
);

  logic        is_load;
  logic [31:0] x;

  always_comb begin
    is_load  = (opcode == OPC_LOAD);
    is_store = (opcode == OPC_STORE);
    is_mem   = is_load | is_store;

    be = lane_mask(funct3[1:0], addr_lo);
    unique case (funct3[1:0])
      2'b00:   wdata = {4{store_data[7:0]}};
      2'b01:   wdata = {2{store_data[15:0]}};
      default: wdata = store_data;
    endcase

    fault = 1'b0;
    if (is_load) begin
      unique case (funct3)
        F3_LB, F3_LBU: fault = 1'b0;
        F3_LH, F3_LHU: fault = addr_lo[0];
        F3_LW:         fault = |addr_lo;
        default:       fault = 1'b1;
      endcase
    end else if (is_store) begin
      unique case (funct3)
        F3_SB:   fault = 1'b0;
        F3_SH:   fault = addr_lo[0];
        F3_SW:   fault = |addr_lo;
        default: fault = 1'b1;
      endcase
    end

    x = rdata >> {addr_lo, 3'b000};
    unique case (funct3)
      F3_LB:   lmd = {{24{x[7]}}, x[7:0]};
      F3_LH:   lmd = {{16{x[15]}}, x[15:0]};
      F3_LW:   lmd = x;
      F3_LBU:  lmd = {24'h0, x[7:0]};
      F3_LHU:  lmd = {16'h0, x[15:0]};
      default: lmd = '0;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// MEM stage of the non-pipelined RV32I core.
//   EX_MEM_*  : input bundle (valid/ready handshake, accepted only in IDLE)
//   DMEM_*    : req/ack data-memory port, request held until ACK or timeout
//   MEM_WB_*  : registered output bundle, MEM_WB_VALID pulses for one cycle
module memory_access
  import memory_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        EX_MEM_VALID,
  output logic        EX_MEM_READY,
  input  logic [31:0] EX_MEM_ALU_OUT,
  input  logic [31:0] EX_MEM_IR,
  input  logic [31:0] EX_MEM_B,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [3:0]  DMEM_BE,
  output logic [31:0] DMEM_ADDR,
  output logic [31:0] DMEM_WDATA,
  input  logic [31:0] DMEM_RDATA,
  input  logic        DMEM_ACK,
  output logic        MEM_WB_VALID,
  output logic [31:0] MEM_WB_ALU_OUT,
  output logic [31:0] MEM_WB_LMD,
  output logic [31:0] MEM_WB_IR,
  output logic        MEM_WB_FAULT
);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [31:0]     alu_q, alu_d, ir_q, ir_d, b_q, b_d;
  logic            req_q, req_d, we_q, we_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     addr_q, addr_d, wdata_q, wdata_d;
  logic            wb_valid_q, wb_valid_d, wb_fault_q, wb_fault_d;
  logic [31:0]     wb_alu_q, wb_alu_d, wb_lmd_q, wb_lmd_d, wb_ir_q, wb_ir_d;

  logic            sel_in;
  logic [31:0]     alu_sel, ir_sel, b_sel;
  logic            lsu_is_mem, lsu_is_store, lsu_fault;
  logic [3:0]      lsu_be;
  logic [31:0]     lsu_wdata, lsu_lmd;
  logic            timeout_hit;

  // The alignment unit classifies the incoming bundle while IDLE (so the
  // accept edge can route straight to WB), and extracts load data from the
  // captured bundle while ACCESS.
  assign sel_in  = (state_q == IDLE);
  assign alu_sel = sel_in ? EX_MEM_ALU_OUT : alu_q;
  assign ir_sel  = sel_in ? EX_MEM_IR      : ir_q;
  assign b_sel   = sel_in ? EX_MEM_B       : b_q;

  memory_access_lsu_align u_lsu_align (
    .opcode     (ir_sel[6:0]),
    .funct3     (ir_sel[14:12]),
    .addr_lo    (alu_sel[1:0]),
    .store_data (b_sel),
    .rdata      (DMEM_RDATA),
    .is_mem     (lsu_is_mem),
    .is_store   (lsu_is_store),
    .fault      (lsu_fault),
    .be         (lsu_be),
    .wdata      (lsu_wdata),
    .lmd        (lsu_lmd)
  );

  // Counter holds the number of completed no-ACK cycles, so the final
  // no-ACK cycle is the one where it reads TIMEOUT_CYCLES-1.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_d      = alu_q;
    ir_d       = ir_q;
    b_d        = b_q;
    req_d      = req_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wb_valid_d = 1'b0;
    wb_alu_d   = wb_alu_q;
    wb_lmd_d   = wb_lmd_q;
    wb_ir_d    = wb_ir_q;
    wb_fault_d = wb_fault_q;

    unique case (state_q)
      IDLE: begin
        if (EX_MEM_VALID) begin
          alu_d = EX_MEM_ALU_OUT;
          ir_d  = EX_MEM_IR;
          b_d   = EX_MEM_B;
          if (lsu_is_mem && !lsu_fault) begin
            state_d = ACCESS;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = lsu_is_store;
            be_d    = lsu_be;
            addr_d  = {EX_MEM_ALU_OUT[31:2], 2'b00};
            wdata_d = lsu_wdata;
          end else begin
            state_d    = WB;
            wb_valid_d = 1'b1;
            wb_alu_d   = EX_MEM_ALU_OUT;
            wb_ir_d    = EX_MEM_IR;
            wb_lmd_d   = '0;
            wb_fault_d = lsu_fault;
          end
        end
      end
      ACCESS: begin
        if (DMEM_ACK || timeout_hit) begin
          state_d    = WB;
          cnt_d      = '0;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_alu_d   = alu_q;
          wb_ir_d    = ir_q;
          wb_lmd_d   = (DMEM_ACK && !we_q) ? lsu_lmd : '0;
          wb_fault_d = !DMEM_ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      alu_q      <= '0;
      ir_q       <= '0;
      b_q        <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_alu_q   <= '0;
      wb_lmd_q   <= '0;
      wb_ir_q    <= '0;
      wb_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_q      <= alu_d;
      ir_q       <= ir_d;
      b_q        <= b_d;
      req_q      <= req_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wb_valid_q <= wb_valid_d;
      wb_alu_q   <= wb_alu_d;
      wb_lmd_q   <= wb_lmd_d;
      wb_ir_q    <= wb_ir_d;
      wb_fault_q <= wb_fault_d;
    end
  end

  assign EX_MEM_READY   = (state_q == IDLE);
  assign DMEM_REQ       = req_q;
  assign DMEM_WE        = we_q;
  assign DMEM_BE        = be_q;
  assign DMEM_ADDR      = addr_q;
  assign DMEM_WDATA     = wdata_q;
  assign MEM_WB_VALID   = wb_valid_q;
  assign MEM_WB_ALU_OUT = wb_alu_q;
  assign MEM_WB_LMD     = wb_lmd_q;
  assign MEM_WB_IR      = wb_ir_q;
  assign MEM_WB_FAULT   = wb_fault_q;

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        EX_MEM_VALID, EX_MEM_READY;
  logic [31:0] EX_MEM_ALU_OUT, EX_MEM_IR, EX_MEM_B;
  logic        DMEM_REQ, DMEM_WE, DMEM_ACK;
  logic [3:0]  DMEM_BE;
  logic [31:0] DMEM_ADDR, DMEM_WDATA, DMEM_RDATA;
  logic        MEM_WB_VALID, MEM_WB_FAULT;
  logic [31:0] MEM_WB_ALU_OUT, MEM_WB_LMD, MEM_WB_IR;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] lmd;
    logic [31:0] ir;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_ALU = 7'b0110011;

  memory_access #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .EX_MEM_VALID   (EX_MEM_VALID),
    .EX_MEM_READY   (EX_MEM_READY),
    .EX_MEM_ALU_OUT (EX_MEM_ALU_OUT),
    .EX_MEM_IR      (EX_MEM_IR),
    .EX_MEM_B       (EX_MEM_B),
    .DMEM_REQ       (DMEM_REQ),
    .DMEM_WE        (DMEM_WE),
    .DMEM_BE        (DMEM_BE),
    .DMEM_ADDR      (DMEM_ADDR),
    .DMEM_WDATA     (DMEM_WDATA),
    .DMEM_RDATA     (DMEM_RDATA),
    .DMEM_ACK       (DMEM_ACK),
    .MEM_WB_VALID   (MEM_WB_VALID),
    .MEM_WB_ALU_OUT (MEM_WB_ALU_OUT),
    .MEM_WB_LMD     (MEM_WB_LMD),
    .MEM_WB_IR      (MEM_WB_IR),
    .MEM_WB_FAULT   (MEM_WB_FAULT)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_ir(input logic [6:0] opc, input logic [2:0] f3);
    return {17'h0A5C3, f3, 5'd5, opc};
  endfunction

  // Scoreboard consumer: every writeback pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && MEM_WB_VALID) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL wb_unexpected: alu=%h ir=%h fault=%b, required no writeback",
                 MEM_WB_ALU_OUT, MEM_WB_IR, MEM_WB_FAULT);
      end else begin
        mon_e = sb.pop_front();
        if (MEM_WB_ALU_OUT !== mon_e.alu || MEM_WB_LMD !== mon_e.lmd ||
            MEM_WB_IR !== mon_e.ir || MEM_WB_FAULT !== mon_e.fault)
          $display("FAIL wb_bundle: got alu=%h lmd=%h ir=%h fault=%b, required alu=%h lmd=%h ir=%h fault=%b",
                   MEM_WB_ALU_OUT, MEM_WB_LMD, MEM_WB_IR, MEM_WB_FAULT,
                   mon_e.alu, mon_e.lmd, mon_e.ir, mon_e.fault);
        else n_pass++;
      end
    end
  end

  // Presents one bundle for one cycle once the stage is ready; returns at the
  // falling edge right after the accepting clock edge.
  task automatic send(input logic [31:0] alu, input logic [31:0] ir, input logic [31:0] b);
    int unsigned n = 0;
    @(negedge clk);
    while (!EX_MEM_READY && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!EX_MEM_READY) begin
      n_checks++;
      $display("FAIL send_ready: READY=%b after %0d cycles, required 1", EX_MEM_READY, n);
    end
    EX_MEM_ALU_OUT = alu;
    EX_MEM_IR      = ir;
    EX_MEM_B       = b;
    EX_MEM_VALID   = 1'b1;
    @(negedge clk);
    EX_MEM_VALID   = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (EX_MEM_READY !== 1'b1 || DMEM_REQ !== 1'b0 || DMEM_WE !== 1'b0 || DMEM_BE !== 4'h0 ||
        DMEM_ADDR !== 32'h0 || DMEM_WDATA !== 32'h0 || MEM_WB_VALID !== 1'b0 ||
        MEM_WB_ALU_OUT !== 32'h0 || MEM_WB_LMD !== 32'h0 || MEM_WB_IR !== 32'h0 ||
        MEM_WB_FAULT !== 1'b0)
      $display("FAIL reset_state: ready=%b req=%b we=%b be=%h addr=%h wdata=%h valid=%b alu=%h lmd=%h ir=%h fault=%b, required ready=1 and all others 0",
               EX_MEM_READY, DMEM_REQ, DMEM_WE, DMEM_BE, DMEM_ADDR, DMEM_WDATA,
               MEM_WB_VALID, MEM_WB_ALU_OUT, MEM_WB_LMD, MEM_WB_IR, MEM_WB_FAULT);
    else n_pass++;
  endtask

  task automatic test_passthrough();
    logic [31:0] ir = mk_ir(OP_ALU, 3'b000);
    sb.push_back('{alu: 32'h0000_1234, lmd: 32'h0, ir: ir, fault: 1'b0});
    send(32'h0000_1234, ir, 32'h5555_5555);
    n_checks++;
    if (MEM_WB_VALID !== 1'b1 || DMEM_REQ !== 1'b0 || EX_MEM_READY !== 1'b0)
      $display("FAIL pass_latency: valid=%b req=%b ready=%b, required 1 0 0",
               MEM_WB_VALID, DMEM_REQ, EX_MEM_READY);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (MEM_WB_VALID !== 1'b0 || EX_MEM_READY !== 1'b1 || MEM_WB_ALU_OUT !== 32'h0000_1234)
      $display("FAIL pass_pulse: valid=%b ready=%b alu=%h, required 0 1 00001234",
               MEM_WB_VALID, EX_MEM_READY, MEM_WB_ALU_OUT);
    else n_pass++;
  endtask

  task automatic test_store();
    logic [31:0] ir = mk_ir(OP_ST, 3'b000);
    sb.push_back('{alu: 32'h0000_0103, lmd: 32'h0, ir: ir, fault: 1'b0});
    send(32'h0000_0103, ir, 32'h1234_56AB);
    // A bundle offered while busy must not be taken.
    EX_MEM_ALU_OUT = 32'hDEAD_0000;
    EX_MEM_IR      = mk_ir(OP_ALU, 3'b111);
    EX_MEM_VALID   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (DMEM_REQ !== 1'b1 || DMEM_WE !== 1'b1 || DMEM_BE !== 4'b1000 ||
          DMEM_ADDR !== 32'h0000_0100 || DMEM_WDATA !== 32'hABAB_ABAB)
        $display("FAIL sb_wait%0d: req=%b we=%b be=%b addr=%h wdata=%h, required 1 1 1000 00000100 abababab",
                 k, DMEM_REQ, DMEM_WE, DMEM_BE, DMEM_ADDR, DMEM_WDATA);
      else n_pass++;
      @(negedge clk);
    end
    EX_MEM_VALID = 1'b0;
    DMEM_ACK     = 1'b1;
    @(negedge clk);
    DMEM_ACK     = 1'b0;
    n_checks++;
    if (MEM_WB_VALID !== 1'b1 || DMEM_REQ !== 1'b0)
      $display("FAIL sb_done: valid=%b req=%b, required 1 0", MEM_WB_VALID, DMEM_REQ);
    else n_pass++;
  endtask

  task automatic test_loads();
    logic [2:0]  f3 [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
    logic [31:0] la [6] = '{32'h102, 32'h102, 32'h102, 32'h102, 32'h204, 32'h001};
    logic [31:0] lr [6] = '{32'h0080_0000, 32'h0080_0000, 32'h8001_0000, 32'h8001_0000,
                            32'hDEAD_BEEF, 32'h0000_7F00};
    logic [31:0] lx [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001,
                            32'hDEAD_BEEF, 32'h0000_007F};
    logic [3:0]  lb [6] = '{4'b0100, 4'b0100, 4'b1100, 4'b1100, 4'b1111, 4'b0010};
    for (int i = 0; i < 6; i++) begin
      logic [31:0] ir = mk_ir(OP_LD, f3[i]);
      sb.push_back('{alu: la[i], lmd: lx[i], ir: ir, fault: 1'b0});
      send(la[i], ir, 32'hFFFF_FFFF);
      n_checks++;
      if (DMEM_REQ !== 1'b1 || DMEM_WE !== 1'b0 || DMEM_BE !== lb[i] ||
          DMEM_ADDR !== (la[i] & ~32'h3))
        $display("FAIL load%0d_req: req=%b we=%b be=%b addr=%h, required 1 0 %b %h",
                 i, DMEM_REQ, DMEM_WE, DMEM_BE, DMEM_ADDR, lb[i], la[i] & ~32'h3);
      else n_pass++;
      DMEM_RDATA = lr[i];
      DMEM_ACK   = 1'b1;
      @(negedge clk);
      DMEM_ACK   = 1'b0;
      DMEM_RDATA = 32'hA5A5_A5A5;
      n_checks++;
      if (MEM_WB_VALID !== 1'b1 || DMEM_REQ !== 1'b0)
        $display("FAIL load%0d_done: valid=%b req=%b, required 1 0", i, MEM_WB_VALID, DMEM_REQ);
      else n_pass++;
    end
  endtask

  task automatic test_faults();
    logic [6:0]  op [8] = '{OP_LD, OP_LD, OP_LD, OP_ST, OP_ST, OP_LD, OP_LD, OP_ST};
    logic [2:0]  f3 [8] = '{3'b010, 3'b001, 3'b101, 3'b010, 3'b001, 3'b011, 3'b110, 3'b011};
    logic [31:0] fa [8] = '{32'h202, 32'h201, 32'h203, 32'h001, 32'h003, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ir = mk_ir(op[i], f3[i]);
      sb.push_back('{alu: fa[i], lmd: 32'h0, ir: ir, fault: 1'b1});
      send(fa[i], ir, 32'h0BAD_F00D);
      n_checks++;
      if (DMEM_REQ !== 1'b0 || MEM_WB_VALID !== 1'b1)
        $display("FAIL fault%0d: req=%b valid=%b, required 0 1", i, DMEM_REQ, MEM_WB_VALID);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    logic [31:0] ir = mk_ir(OP_LD, 3'b010);
    sb.push_back('{alu: 32'h0000_0300, lmd: 32'h0, ir: ir, fault: 1'b1});
    send(32'h0000_0300, ir, 32'h0);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (DMEM_REQ !== 1'b1 || MEM_WB_VALID !== 1'b0)
        $display("FAIL to_wait%0d: req=%b valid=%b, required 1 0", k, DMEM_REQ, MEM_WB_VALID);
      else n_pass++;
      @(negedge clk);
    end
    n_checks++;
    if (DMEM_REQ !== 1'b0 || MEM_WB_VALID !== 1'b1)
      $display("FAIL to_fire: req=%b valid=%b, required 0 1", DMEM_REQ, MEM_WB_VALID);
    else n_pass++;
    DMEM_RDATA = 32'h1111_1111;
    DMEM_ACK   = 1'b1;
    repeat (2) @(negedge clk);
    DMEM_ACK   = 1'b0;
    n_checks++;
    if (EX_MEM_READY !== 1'b1 || DMEM_REQ !== 1'b0 || MEM_WB_FAULT !== 1'b1)
      $display("FAIL to_late_ack: ready=%b req=%b fault=%b, required 1 0 1",
               EX_MEM_READY, DMEM_REQ, MEM_WB_FAULT);
    else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] ir = mk_ir(OP_LD, 3'b010);
    send(32'h0000_0400, ir, 32'h0);
    n_checks++;
    if (DMEM_REQ !== 1'b1)
      $display("FAIL rst_pre: req=%b, required 1", DMEM_REQ);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (DMEM_REQ !== 1'b0)
      $display("FAIL rst_async_req: req=%b, required 0", DMEM_REQ);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (MEM_WB_VALID !== 1'b0 || EX_MEM_READY !== 1'b1)
      $display("FAIL rst_hold: valid=%b ready=%b, required 0 1", MEM_WB_VALID, EX_MEM_READY);
    else n_pass++;
    rst_n = 1'b1;
    sb.push_back('{alu: 32'h0000_0404, lmd: 32'h1234_5678, ir: ir, fault: 1'b0});
    send(32'h0000_0404, ir, 32'h0);
    DMEM_RDATA = 32'h1234_5678;
    DMEM_ACK   = 1'b1;
    @(negedge clk);
    DMEM_ACK   = 1'b0;
    n_checks++;
    if (MEM_WB_VALID !== 1'b1)
      $display("FAIL rst_next_lw: valid=%b, required 1", MEM_WB_VALID);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ir = mk_ir(OP_ALU, 3'b110);
    sb.push_back('{alu: 32'hCAFE_0001, lmd: 32'h0, ir: ir, fault: 1'b0});
    sb.push_back('{alu: 32'h0000_0007, lmd: 32'h0, ir: ir, fault: 1'b0});
    send(32'hCAFE_0001, ir, 32'h0);
    send(32'h0000_0007, ir, 32'h0);
    n_checks++;
    if (MEM_WB_VALID !== 1'b1 || MEM_WB_ALU_OUT !== 32'h0000_0007)
      $display("FAIL b2b_second: valid=%b alu=%h, required 1 00000007", MEM_WB_VALID, MEM_WB_ALU_OUT);
    else n_pass++;
  endtask

  initial begin
    int pending;
    rst_n          = 1'b0;
    EX_MEM_VALID   = 1'b0;
    EX_MEM_ALU_OUT = '0;
    EX_MEM_IR      = '0;
    EX_MEM_B       = '0;
    DMEM_RDATA     = '0;
    DMEM_ACK       = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_passthrough();
    test_store();
    test_loads();
    test_faults();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    repeat (3) @(negedge clk);
    pending = sb.size();
    n_checks++;
    if (pending != 0)
      $display("FAIL sb_drain: %0d expected writebacks never arrived, required 0", pending);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
